// File: rtl/myproject_mul_arb_pkg.sv
// Shared constants and types for the shared-multiplier arbiter.
package myproject_mul_arb_pkg;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DIN_WIDTH_DEF  = 22;
    localparam int DOUT_WIDTH_DEF = 38;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    typedef struct packed {
        logic signed [DIN_WIDTH_DEF-1:0]         a;
        logic signed [DIN_WIDTH_DEF-1:0]         b;
        logic [id_width(NUM_REQ_DEF)-1:0]        id;
    } mul_op_t;

endpackage

// File: rtl/myproject_rr_arb.sv
// Combinational round-robin grant: first set req bit at or above ptr, wrapping.
module myproject_rr_arb
    import myproject_mul_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDW    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx
);

    always_comb begin
        int   idx;
        logic found;
        // NOTE: every output and temporary gets a default first, so no path leaves a latch.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        if (en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!found && req[idx]) begin
                    found    = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_idx  = IDW'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/myproject_mul_arbiter.sv
// One signed multiplier shared round-robin among NUM_REQ requesters,
// with an operand stage and a product stage behind a valid/ready response port.
module myproject_mul_arbiter
    import myproject_mul_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]    req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]    req_b,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DOUT_WIDTH-1:0]           rsp_data,
    output logic [ID_WIDTH-1:0]             rsp_id,
    output logic                            busy
);

    logic [ID_WIDTH-1:0]          rr_ptr;
    logic [ID_WIDTH-1:0]          gnt_idx;
    logic                         s1_valid;
    logic signed [DIN_WIDTH-1:0]  s1_a;
    logic signed [DIN_WIDTH-1:0]  s1_b;
    logic [ID_WIDTH-1:0]          s1_id;
    logic signed [DOUT_WIDTH-1:0] prod;
    logic                         s2_adv;
    logic                         s1_adv;

    assign s2_adv = !rsp_valid || rsp_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign busy   = s1_valid || rsp_valid;

    // Gating with reset keeps req_ready low while the pipeline is being cleared.
    myproject_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .en      (s1_adv && ap_rst_n),
        .gnt     (req_ready),
        .gnt_idx (gnt_idx)
    );

    // Operands are sign-extended to the result width; the low bits of the product are exact.
    assign prod = DOUT_WIDTH'(s1_a) * DOUT_WIDTH'(s1_b);

    always_ff @(posedge ap_clk) begin
        // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
        if (!ap_rst_n) begin
            rr_ptr    <= '0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
        end else begin
            if (|req_ready) begin
                rr_ptr <= (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            end
            if (s1_adv) begin
                s1_valid <= |req_ready;
                if (|req_ready) begin
                    s1_a  <= req_a[gnt_idx*DIN_WIDTH +: DIN_WIDTH];
                    s1_b  <= req_b[gnt_idx*DIN_WIDTH +: DIN_WIDTH];
                    s1_id <= gnt_idx;
                end
            end
            if (s2_adv) begin
                rsp_valid <= s1_valid;
                rsp_data  <= prod;
                rsp_id    <= s1_id;
            end
        end
    end

endmodule

// File: tb/tb_myproject_mul_arbiter.sv
// Bench for myproject_mul_arbiter: transaction-level model with a per-cycle compare,
// plus directed scenarios with hand-computed expectations.
module tb_myproject_mul_arbiter;

    localparam int NR = 4;
    localparam int DW = 22;
    localparam int OW = 38;
    localparam int IW = 2;

    logic              ap_clk;
    logic              ap_rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_a;
    logic [NR*DW-1:0]  req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [OW-1:0]     rsp_data;
    logic [IW-1:0]     rsp_id;
    logic              busy;

    int checks = 0;
    int errors = 0;

    myproject_mul_arbiter dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    typedef struct {
        int             edge_n;
        logic [IW-1:0]  id;
        logic [OW-1:0]  data;
    } op_t;

    op_t q[$];
    int  mptr     = 0;
    int  edge_cnt = 0;
    bit  live     = 0;

    function automatic logic [OW-1:0] mprod(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[OW-1:0];
    endfunction

    // Outputs are compared on the falling edge; the model then applies the coming rising edge.
    always @(negedge ap_clk) begin
        int            g;
        bit            adv;
        bit            exp_rv;
        logic [NR-1:0] exp_rdy;
        op_t           o;
        g       = -1;
        exp_rdy = '0;
        adv     = (q.size() < 2) || rsp_ready;
        exp_rv  = (q.size() > 0) && (q[0].edge_n < edge_cnt);
        if (ap_rst_n && adv) begin
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (mptr + k) % NR;
                if (g < 0 && req_valid[idx]) g = idx;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        if (live) begin
            check("cmp_req_ready", 64'(req_ready), 64'(exp_rdy));
            check("cmp_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            check("cmp_busy", 64'(busy), 64'(q.size() > 0));
            if (exp_rv) begin
                check("cmp_rsp_data", 64'(rsp_data), 64'(q[0].data));
                check("cmp_rsp_id", 64'(rsp_id), 64'(q[0].id));
            end
        end
        edge_cnt++;
        if (!ap_rst_n) begin
            q.delete();
            mptr = 0;
            live = 1;
        end else if (live) begin
            if (exp_rv && rsp_ready) void'(q.pop_front());
            if (g >= 0) begin
                o.edge_n = edge_cnt;
                o.id     = IW'(g);
                o.data   = mprod(req_a[g*DW +: DW], req_b[g*DW +: DW]);
                q.push_back(o);
                mptr = (g + 1) % NR;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_op(input int i, input int a, input int b);
        req_a[i*DW +: DW] = DW'(a);
        req_b[i*DW +: DW] = DW'(b);
    endtask

    task automatic wait_accept(input int i);
        bit ok;
        ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge ap_clk);
            if (req_ready[i]) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 64'(0), 64'(1));
        @(posedge ap_clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic single(input int i, input int a, input int b, input logic [OW-1:0] exp_d);
        repeat (3) @(posedge ap_clk);
        #1;
        set_op(i, a, b);
        req_valid[i] = 1'b1;
        wait_accept(i);
        @(negedge ap_clk);
        check("lat_not_yet", 64'(rsp_valid), 64'(0));
        @(negedge ap_clk);
        check("lat_valid", 64'(rsp_valid), 64'(1));
        check("single_data", 64'(rsp_data), 64'(exp_d));
        check("single_id", 64'(rsp_id), 64'(i));
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    initial begin
        logic [NR-1:0] g;
        logic [OW-1:0] hold_d;
        logic [IW-1:0] hold_id;
        int            nacc;
        ap_rst_n  = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Reset: requests present but must not be accepted.
        @(negedge ap_clk);
        check("rst_req_ready", 64'(req_ready), 64'(0));
        @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        @(posedge ap_clk);
        #1;
        req_valid = '0;
        ap_rst_n  = 1'b1;

        // Single op: -3 * 5 = -15.
        single(1, -3, 5, 38'h3FFFFFFFF1);

        // All four requesting from reset: grants 0..3, responses in order.
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, i + 1, -(i + 2));
        req_valid = '1;
        for (int c = 0; c < 6; c++) begin
            @(negedge ap_clk);
            if (c < 4) check("all4_grant", 64'(req_ready), 64'(1 << c));
            if (c >= 2) begin
                check("all4_rsp_valid", 64'(rsp_valid), 64'(1));
                check("all4_rsp_id", 64'(rsp_id), 64'(c - 2));
            end
            @(posedge ap_clk);
            #1;
            if (c < 4) req_valid[c] = 1'b0;
        end

        // Pointer back at 0, then wrap-around from 3 to 0.
        req_valid = 4'b1001;
        @(negedge ap_clk);
        check("ptr_back_to_0", 64'(req_ready), 64'(4'b0001));
        @(posedge ap_clk);
        #1;
        req_valid = 4'b1000;
        @(negedge ap_clk);
        check("grant_3_alone", 64'(req_ready), 64'(4'b1000));
        @(posedge ap_clk);
        #1;
        req_valid = 4'b1001;
        @(negedge ap_clk);
        check("wrap_to_0", 64'(req_ready), 64'(4'b0001));
        @(posedge ap_clk);
        #1;
        req_valid = '0;

        // Overflow wraps modulo 2^38.
        single(2, 2097151, 2097151, 38'h3FFFC00001);

        // Backpressure: exactly two accepted, output held stable, nothing lost afterwards.
        repeat (2) @(posedge ap_clk);
        #1;
        for (int i = 0; i < NR; i++) set_op(i, 100 + i, -7 * (i + 1));
        rsp_ready = 1'b0;
        req_valid = '1;
        nacc      = 0;
        hold_d    = '0;
        hold_id   = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge ap_clk);
            g = req_ready;
            nacc += $countones(g);
            if (c >= 2) check("bp_full_no_ready", 64'(g), 64'(0));
            if (c == 2) begin
                hold_d  = rsp_data;
                hold_id = rsp_id;
            end
            if (c == 3) begin
                check("bp_hold_data", 64'(rsp_data), 64'(hold_d));
                check("bp_hold_id", 64'(rsp_id), 64'(hold_id));
            end
            @(posedge ap_clk);
            #1;
            req_valid = req_valid & ~g;
        end
        check("bp_accept_count", 64'(nacc), 64'(2));
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (4) @(negedge ap_clk);
        check("bp_drained", 64'(busy), 64'(0));
        @(posedge ap_clk);
        #1;

        // Reset while an operation sits in stage 1: it must vanish.
        set_op(1, 7, 9);
        req_valid[1] = 1'b1;
        wait_accept(1);
        do_reset();
        @(negedge ap_clk);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        repeat (3) begin
            @(negedge ap_clk);
            check("rst_mid_no_ghost", 64'(rsp_valid), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
